// File: rtl/inst_queue_dual_if.sv
// Fetch-to-decode instruction queue bus: two enqueue slots in, two show-ahead
// entries out, plus occupancy and status.
interface inst_queue_dual_if #(
    parameter int INST_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic              rdy;
    logic              clear;
    logic [1:0]        enq_num;
    logic [INST_W-1:0] enq_inst0;
    logic [INST_W-1:0] enq_inst1;
    logic [ADDR_W-1:0] enq_pc0;
    logic [ADDR_W-1:0] enq_pc1;
    logic [1:0]        deq_num;
    logic [1:0]        out_valid;
    logic [INST_W-1:0] out_inst0;
    logic [INST_W-1:0] out_inst1;
    logic [ADDR_W-1:0] out_pc0;
    logic [ADDR_W-1:0] out_pc1;
    logic [CNT_W-1:0]  count;
    logic              almost_full;
    logic              overflow;
    logic              underflow;

    // Pipeline side: drives enqueue/dequeue requests, observes the queue.
    modport master (
        output rdy, clear, enq_num, enq_inst0, enq_inst1, enq_pc0, enq_pc1, deq_num,
        input  out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
        input  count, almost_full, overflow, underflow
    );

    // Queue side.
    modport slave (
        input  rdy, clear, enq_num, enq_inst0, enq_inst1, enq_pc0, enq_pc1, deq_num,
        output out_valid, out_inst0, out_inst1, out_pc0, out_pc1,
        output count, almost_full, overflow, underflow
    );
endinterface

// File: rtl/inst_queue_dual.sv
// Dual-ported show-ahead instruction queue between fetch and decode.
// Circular buffer with explicit occupancy count; all-or-nothing enqueue of up
// to two entries, up to two retired per cycle, sticky overflow/underflow.
module inst_queue_dual #(
    parameter int INST_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 16,
    parameter int AFULL_SLACK = 2
) (
    input logic              clk,
    input logic              rst_n,
    inst_queue_dual_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] SLACK_C = CNT_W'(AFULL_SLACK);

    // Storage is never reset; readers only see entries covered by count.
    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic [CNT_W-1:0] enq_n, deq_n, free_n, acc_enq, eff_deq;
    logic             enq_ok;
    logic             wr_go;

    logic [PTR_W-1:0]  wr_addr [2];
    logic [1:0]        wr_en;
    logic [INST_W-1:0] wr_inst [2];
    logic [ADDR_W-1:0] wr_pc   [2];

    logic [PTR_W-1:0]  rd_addr [2];
    logic [1:0]        rd_valid;
    logic [INST_W-1:0] rd_inst [2];
    logic [ADDR_W-1:0] rd_pc   [2];

    // Next-state decode: space check and dequeue clamp both use the count
    // from before this edge, so a retire never makes room for a same-cycle
    // enqueue.
    always_comb begin
        enq_n          = (bus.enq_num == 2'd3) ? '0 : CNT_W'(bus.enq_num);
        deq_n          = (bus.deq_num == 2'd3) ? '0 : CNT_W'(bus.deq_num);
        free_n         = DEPTH_C - count_reg;
        enq_ok         = (enq_n <= free_n);
        acc_enq        = enq_ok ? enq_n : '0;
        eff_deq        = (deq_n > count_reg) ? count_reg : deq_n;
        wr_go          = 1'b0;
        head_next      = head_reg;
        tail_next      = tail_reg;
        count_next     = count_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
        if (bus.clear) begin
            head_next      = '0;
            tail_next      = '0;
            count_next     = '0;
            overflow_next  = 1'b0;
            underflow_next = 1'b0;
        end else if (bus.rdy) begin
            wr_go      = 1'b1;
            head_next  = head_reg + PTR_W'(eff_deq);
            tail_next  = tail_reg + PTR_W'(acc_enq);
            count_next = count_reg + acc_enq - eff_deq;
            if (!enq_ok) begin
                overflow_next = 1'b1;
            end
            if (deq_n > count_reg) begin
                underflow_next = 1'b1;
            end
        end
    end

    assign wr_inst[0] = bus.enq_inst0;
    assign wr_inst[1] = bus.enq_inst1;
    assign wr_pc[0]   = bus.enq_pc0;
    assign wr_pc[1]   = bus.enq_pc1;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slot
            // Write slot gi lands at tail+gi when the accepted batch covers it.
            assign wr_addr[gi] = tail_reg + PTR_W'(gi);
            assign wr_en[gi]   = wr_go && (acc_enq > CNT_W'(gi));
            // Show-ahead read of head+gi, zeroed when that entry is absent.
            assign rd_addr[gi]  = head_reg + PTR_W'(gi);
            assign rd_valid[gi] = (count_reg > CNT_W'(gi));
            assign rd_inst[gi]  = rd_valid[gi] ? inst_mem[rd_addr[gi]] : '0;
            assign rd_pc[gi]    = rd_valid[gi] ? pc_mem[rd_addr[gi]]   : '0;
        end
    endgenerate

    // Entry storage write; two independent slots, no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (wr_en[i]) begin
                inst_mem[wr_addr[i]] <= wr_inst[i];
                pc_mem[wr_addr[i]]   <= wr_pc[i];
            end
        end
    end

    // Pointer, occupancy and sticky error state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg      <= '0;
            tail_reg      <= '0;
            count_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            count_reg     <= count_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.out_valid   = rd_valid;
    assign bus.out_inst0   = rd_inst[0];
    assign bus.out_inst1   = rd_inst[1];
    assign bus.out_pc0     = rd_pc[0];
    assign bus.out_pc1     = rd_pc[1];
    assign bus.count       = count_reg;
    assign bus.almost_full = (free_n <= SLACK_C);
    assign bus.overflow    = overflow_reg;
    assign bus.underflow   = underflow_reg;
endmodule

// File: tb/tb_inst_queue_dual.sv
// Bench for inst_queue_dual: hand-computed vector table, targeted multi-cycle
// sequences, then random traffic against a queue-based reference model.
module tb_inst_queue_dual;
    localparam int INST_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 16;
    localparam int SLACK  = 2;

    logic clk;
    logic rst_n;

    inst_queue_dual_if #(.INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    inst_queue_dual #(
        .INST_W(INST_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .AFULL_SLACK(SLACK)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain FIFO of entries plus sticky flags.
    logic [31:0] mq_inst [$];
    logic [31:0] mq_pc   [$];
    logic        m_ovf;
    logic        m_udf;

    typedef struct {
        logic        rdy;
        logic        clr;
        logic [1:0]  en;
        logic [1:0]  dn;
        int          cnt;
        logic [1:0]  vld;
        logic        af;
        logic        ovf;
        logic        udf;
        logic [31:0] pc0;
    } vec_t;
    vec_t vecs [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq_inst.delete();
        mq_pc.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic c, input logic [1:0] en,
                              input logic [1:0] dn, input logic [31:0] i0,
                              input logic [31:0] p0, input logic [31:0] i1,
                              input logic [31:0] p1);
        int e, d, sz;
        if (c) begin
            model_reset();
        end else if (r) begin
            e  = (en == 2'd3) ? 0 : int'(en);
            d  = (dn == 2'd3) ? 0 : int'(dn);
            sz = mq_inst.size();
            if (e > DEPTH - sz) begin
                m_ovf = 1'b1;
            end else begin
                if (e >= 1) begin mq_inst.push_back(i0); mq_pc.push_back(p0); end
                if (e == 2) begin mq_inst.push_back(i1); mq_pc.push_back(p1); end
            end
            if (d > sz) begin
                m_udf = 1'b1;
                d = sz;
            end
            repeat (d) begin
                void'(mq_inst.pop_front());
                void'(mq_pc.pop_front());
            end
        end
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq_inst.size();
        chk({tag, ".count"}, 64'(bus.count), 64'(sz));
        chk({tag, ".out_valid"}, 64'(bus.out_valid), {62'd0, sz >= 2, sz >= 1});
        chk({tag, ".out_inst0"}, 64'(bus.out_inst0), (sz >= 1) ? 64'(mq_inst[0]) : 64'd0);
        chk({tag, ".out_pc0"}, 64'(bus.out_pc0), (sz >= 1) ? 64'(mq_pc[0]) : 64'd0);
        chk({tag, ".out_inst1"}, 64'(bus.out_inst1), (sz >= 2) ? 64'(mq_inst[1]) : 64'd0);
        chk({tag, ".out_pc1"}, 64'(bus.out_pc1), (sz >= 2) ? 64'(mq_pc[1]) : 64'd0);
        chk({tag, ".almost_full"}, 64'(bus.almost_full), 64'((DEPTH - sz) <= SLACK));
        chk({tag, ".overflow"}, 64'(bus.overflow), 64'(m_ovf));
        chk({tag, ".underflow"}, 64'(bus.underflow), 64'(m_udf));
    endtask

    task automatic drive(input logic r, input logic c, input logic [1:0] en,
                         input logic [1:0] dn, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        bus.rdy       = r;
        bus.clear     = c;
        bus.enq_num   = en;
        bus.deq_num   = dn;
        bus.enq_inst0 = i0;
        bus.enq_pc0   = p0;
        bus.enq_inst1 = i1;
        bus.enq_pc1   = p1;
    endtask

    // One clock: drive, advance model, take the edge, sample 1 unit later.
    task automatic cycle(input logic r, input logic c, input logic [1:0] en,
                         input logic [1:0] dn, input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1);
        drive(r, c, en, dn, i0, p0, i1, p1);
        model_step(r, c, en, dn, i0, p0, i1, p1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'd0, 2'd0, '0, '0, '0, '0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic add_vec(input logic r, input logic c, input logic [1:0] en, input logic [1:0] dn,
                           input int cnt, input logic [1:0] vld, input logic af,
                           input logic ovf, input logic udf, input logic [31:0] pc0);
        vec_t v;
        v.rdy = r; v.clr = c; v.en = en; v.dn = dn; v.cnt = cnt; v.vld = vld;
        v.af = af; v.ovf = ovf; v.udf = udf; v.pc0 = pc0;
        vecs.push_back(v);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc_ctr;
        logic [31:0] exp_pc;
        logic        r, c;
        logic [1:0]  en, dn;

        rst_n = 1'b1;
        drive(1'b1, 1'b0, 2'd0, 2'd0, '0, '0, '0, '0);
        model_reset();
        do_reset();

        // Reset state.
        chk("rst.count", 64'(bus.count), 64'd0);
        chk("rst.out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst.out_inst0", 64'(bus.out_inst0), 64'd0);
        chk("rst.out_pc1", 64'(bus.out_pc1), 64'd0);
        chk("rst.almost_full", 64'(bus.almost_full), 64'd0);
        chk("rst.overflow", 64'(bus.overflow), 64'd0);
        chk("rst.underflow", 64'(bus.underflow), 64'd0);

        // Vector table: PCs are handed out 4 apart per offered slot.
        //       rdy clr en dn  cnt vld    af ovf udf pc0
        add_vec(1, 0, 2, 0,  2, 2'b11, 0, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0,  4, 2'b11, 0, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0,  6, 2'b11, 0, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0,  8, 2'b11, 0, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0, 10, 2'b11, 0, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0, 12, 2'b11, 0, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0, 14, 2'b11, 1, 0, 0, 32'd0);
        add_vec(1, 0, 2, 0, 16, 2'b11, 1, 0, 0, 32'd0);
        add_vec(1, 0, 1, 1, 15, 2'b11, 1, 1, 0, 32'd4);
        add_vec(1, 0, 0, 2, 13, 2'b11, 0, 1, 0, 32'd12);
        add_vec(1, 0, 3, 3, 13, 2'b11, 0, 1, 0, 32'd12);
        add_vec(1, 1, 2, 1,  0, 2'b00, 0, 0, 0, 32'd0);
        add_vec(1, 0, 1, 0,  1, 2'b01, 0, 0, 0, 32'd76);
        add_vec(1, 0, 0, 2,  0, 2'b00, 0, 0, 1, 32'd0);
        add_vec(1, 0, 2, 2,  2, 2'b11, 0, 0, 1, 32'd80);
        add_vec(1, 0, 2, 1,  3, 2'b11, 0, 0, 1, 32'd84);
        add_vec(0, 0, 2, 2,  3, 2'b11, 0, 0, 1, 32'd84);

        pc_ctr = 32'd0;
        foreach (vecs[k]) begin
            cycle(vecs[k].rdy, vecs[k].clr, vecs[k].en, vecs[k].dn,
                  pc_ctr + 32'h1000_0000, pc_ctr, pc_ctr + 32'h1000_0004, pc_ctr + 32'd4);
            if (vecs[k].en == 2'd1) pc_ctr += 32'd4;
            if (vecs[k].en == 2'd2) pc_ctr += 32'd8;
            chk($sformatf("vec%0d.count", k), 64'(bus.count), 64'(vecs[k].cnt));
            chk($sformatf("vec%0d.out_valid", k), 64'(bus.out_valid), 64'(vecs[k].vld));
            chk($sformatf("vec%0d.almost_full", k), 64'(bus.almost_full), 64'(vecs[k].af));
            chk($sformatf("vec%0d.overflow", k), 64'(bus.overflow), 64'(vecs[k].ovf));
            chk($sformatf("vec%0d.underflow", k), 64'(bus.underflow), 64'(vecs[k].udf));
            chk($sformatf("vec%0d.out_pc0", k), 64'(bus.out_pc0), 64'(vecs[k].pc0));
        end

        // First enqueue after reset; nothing visible before the edge.
        do_reset();
        drive(1'b1, 1'b0, 2'd2, 2'd0, 32'h0000_0013, 32'h0, 32'h0010_0093, 32'h4);
        #1;
        chk("nobypass.out_valid", 64'(bus.out_valid), 64'd0);
        chk("nobypass.count", 64'(bus.count), 64'd0);
        cycle(1'b1, 1'b0, 2'd2, 2'd0, 32'h0000_0013, 32'h0, 32'h0010_0093, 32'h4);
        chk("first.out_valid", 64'(bus.out_valid), 64'd3);
        chk("first.out_inst0", 64'(bus.out_inst0), 64'h0000_0013);
        chk("first.out_inst1", 64'(bus.out_inst1), 64'h0010_0093);
        chk("first.out_pc0", 64'(bus.out_pc0), 64'h0);
        chk("first.out_pc1", 64'(bus.out_pc1), 64'h4);
        chk("first.count", 64'(bus.count), 64'd2);

        // Pointer wrap: sustained 2-in/2-out, head PC advances 8 per cycle.
        for (int k = 1; k <= 20; k++) begin
            exp_pc = 32'(8 * k);
            cycle(1'b1, 1'b0, 2'd2, 2'd2, exp_pc ^ 32'h55, exp_pc, exp_pc ^ 32'hAA, exp_pc + 32'd4);
            chk($sformatf("wrap%0d.out_pc0", k), 64'(bus.out_pc0), 64'(exp_pc));
            chk($sformatf("wrap%0d.out_pc1", k), 64'(bus.out_pc1), 64'(exp_pc + 32'd4));
            chk($sformatf("wrap%0d.count", k), 64'(bus.count), 64'd2);
        end

        // rdy low freezes everything, including error flags.
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 2'd2, 2'd2, 32'hDEAD, 32'hBEEF, 32'hDEAD, 32'hBEEF);
            chk($sformatf("hold%0d.count", k), 64'(bus.count), 64'd2);
            chk($sformatf("hold%0d.out_pc0", k), 64'(bus.out_pc0), 64'd160);
            chk($sformatf("hold%0d.out_valid", k), 64'(bus.out_valid), 64'd3);
            chk($sformatf("hold%0d.overflow", k), 64'(bus.overflow), 64'd0);
            chk($sformatf("hold%0d.underflow", k), 64'(bus.underflow), 64'd0);
        end

        // Asynchronous reset mid-stream: outputs drop before the next edge.
        drive(1'b1, 1'b0, 2'd0, 2'd0, '0, '0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset.out_valid", 64'(bus.out_valid), 64'd0);
        chk("areset.count", 64'(bus.count), 64'd0);
        chk("areset.out_inst0", 64'(bus.out_inst0), 64'd0);
        chk("areset.out_pc0", 64'(bus.out_pc0), 64'd0);
        chk("areset.almost_full", 64'(bus.almost_full), 64'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 2'd1, 2'd0, 32'h1234_5678, 32'h400, '0, '0);
        chk("postrst.count", 64'(bus.count), 64'd1);
        chk("postrst.out_pc0", 64'(bus.out_pc0), 64'h400);
        chk("postrst.out_inst0", 64'(bus.out_inst0), 64'h1234_5678);

        // Random traffic against the reference model, alternating fill and drain bias.
        for (int k = 0; k < 3000; k++) begin
            r = ($urandom_range(0, 7) != 0);
            c = ($urandom_range(0, 99) == 0);
            if (((k / 200) % 2) == 0) begin
                en = 2'($urandom_range(1, 2));
                dn = 2'($urandom_range(0, 1));
            end else begin
                en = 2'($urandom_range(0, 1));
                dn = 2'($urandom_range(1, 3));
            end
            if ($urandom_range(0, 3) == 0) begin
                en = 2'($urandom);
                dn = 2'($urandom);
            end
            cycle(r, c, en, dn, $urandom, $urandom, $urandom, $urandom);
            check_model($sformatf("rnd%0d", k));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
